// File: rtl/if_id_pkg.sv
// Shared types and defaults for the IF/ID skid register.
// The IF_ID_STATS_EN macro enables the optional stall/flush counters in the top.
package if_id_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned ILEN_DEFAULT = 32;
  localparam int unsigned CNT_W        = 32;

  // addi x0,x0,0
  localparam logic [ILEN_DEFAULT-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [ILEN_DEFAULT-1:0] instr;
  } if_id_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;

endpackage : if_id_pkg

// File: rtl/if_id_entry_reg.sv
// Single {pc, instr} holding register with clear-over-load priority.
// Reset and clear both return the entry to the caller-supplied empty value.
module if_id_entry_reg
  import if_id_pkg::*;
#(
  parameter type ENTRY_T = if_id_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   ld_i,
  input  logic   clr_i,
  input  ENTRY_T d_i,
  input  ENTRY_T clr_val_i,
  output ENTRY_T q_o
);

  ENTRY_T entry_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      entry_q <= clr_val_i;
    end else if (ld_i) begin
      entry_q <= d_i;
    end
  end

  assign q_o = entry_q;

endmodule : if_id_entry_reg

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register: valid/ready handshake backed by a 2-entry skid buffer.
// Define IF_ID_STATS_EN to add the stall_cnt/flush_cnt counter outputs.
module if_id_skid_reg
  import if_id_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEFAULT,
  parameter int unsigned     ILEN      = ILEN_DEFAULT,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(NOP_INSTR_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [ILEN-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr
`ifdef IF_ID_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  occ_state_e state_q, state_d;
  logic       out_valid_q, in_ready_q;
  logic       in_fire, out_fire;
  logic       main_ld, main_clr, main_from_skid;
  logic       skid_ld, skid_clr;
  entry_t     main_q, skid_q, main_d, in_entry;
  entry_t     main_empty, skid_empty;

  assign in_fire    = in_valid & in_ready_q;
  assign out_fire   = out_valid_q & out_ready;
  assign in_entry   = '{pc: in_pc, instr: in_instr};
  assign main_empty = '{pc: XLEN'(0), instr: NOP_INSTR};
  assign skid_empty = '{pc: XLEN'(0), instr: ILEN'(0)};
  assign main_d     = main_from_skid ? skid_q : in_entry;

  // Occupancy register; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != EMPTY);
      in_ready_q  <= (state_d != TWO);
    end
  end

  // Next-state and entry control; flush overrides every transition.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_ld = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_ld = 1'b1;
          end else if (in_fire) begin
            state_d = TWO;
            skid_ld = 1'b1;
          end else if (out_fire) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d        = ONE;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          state_d  = EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  if_id_entry_reg #(.ENTRY_T(entry_t)) u_main (
    .clk       (clk),
    .reset     (reset),
    .ld_i      (main_ld),
    .clr_i     (main_clr),
    .d_i       (main_d),
    .clr_val_i (main_empty),
    .q_o       (main_q)
  );

  if_id_entry_reg #(.ENTRY_T(entry_t)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .ld_i      (skid_ld),
    .clr_i     (skid_clr),
    .d_i       (in_entry),
    .clr_val_i (skid_empty),
    .q_o       (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_pc    = main_q.pc;
  assign out_instr = main_q.instr;

`ifdef IF_ID_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid_q && !out_ready) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule : if_id_skid_reg

// File: tb/tb_if_id_skid_reg.sv
// Directed self-checking bench for if_id_skid_reg: vector table plus reset/stats sequences.
// Counter checks are built only when IF_ID_STATS_EN is defined.
module tb_if_id_skid_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_instr;
`ifdef IF_ID_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  if_id_skid_reg #(.XLEN(32), .ILEN(32), .NOP_INSTR(32'h0000_0013)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr)
`ifdef IF_ID_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic        out_ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_ready;
  } vec_t;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  function automatic vec_t mk(input logic f, input logic iv, input logic [31:0] pc,
                              input logic ordy, input logic ev, input logic [31:0] epc,
                              input logic erdy);
    vec_t v;
    v.flush = f; v.in_valid = iv; v.in_pc = pc; v.out_ready = ordy;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_ready = erdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [31:0] epc,
                         input logic erdy);
    chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, "_pc"}, out_pc, ev ? epc : 32'h0);
    chk({tag, "_instr"}, out_instr, ev ? instr_of(epc) : NOP);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(erdy));
  endtask

  task automatic drive(input logic f, input logic iv, input logic [31:0] pc, input logic ordy);
    @(negedge clk);
    flush = f; in_valid = iv; in_pc = pc; in_instr = instr_of(pc); out_ready = ordy;
  endtask

  task automatic step(input logic f, input logic iv, input logic [31:0] pc, input logic ordy);
    drive(f, iv, pc, ordy);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[20];

  initial begin
    // flush, in_valid, in_pc, out_ready | exp valid, exp pc, exp in_ready
    vecs[0]  = mk(0, 1, 32'h00, 1, 1, 32'h00, 1);  // stream: 1-cycle latency
    vecs[1]  = mk(0, 1, 32'h04, 1, 1, 32'h04, 1);
    vecs[2]  = mk(0, 1, 32'h08, 1, 1, 32'h08, 1);
    vecs[3]  = mk(0, 0, 32'h00, 1, 0, 32'h00, 1);
    vecs[4]  = mk(0, 1, 32'h10, 0, 1, 32'h10, 1);  // stall fill
    vecs[5]  = mk(0, 1, 32'h14, 0, 1, 32'h10, 0);
    vecs[6]  = mk(0, 0, 32'h00, 0, 1, 32'h10, 0);
    vecs[7]  = mk(0, 0, 32'h00, 1, 1, 32'h14, 1);
    vecs[8]  = mk(0, 0, 32'h00, 1, 0, 32'h00, 1);
    vecs[9]  = mk(0, 1, 32'h30, 0, 1, 32'h30, 1);  // flush while full
    vecs[10] = mk(0, 1, 32'h34, 0, 1, 32'h30, 0);
    vecs[11] = mk(1, 1, 32'h40, 0, 0, 32'h00, 1);
    vecs[12] = mk(0, 0, 32'h00, 1, 0, 32'h00, 1);
    vecs[13] = mk(0, 1, 32'h44, 0, 1, 32'h44, 1);  // flush drops in_fire, allows out_fire
    vecs[14] = mk(1, 1, 32'h48, 1, 0, 32'h00, 1);
    vecs[15] = mk(0, 0, 32'h00, 1, 0, 32'h00, 1);
    vecs[16] = mk(0, 1, 32'h20, 0, 1, 32'h20, 1);  // in_fire & out_fire in ONE
    vecs[17] = mk(0, 1, 32'h24, 1, 1, 32'h24, 1);
    vecs[18] = mk(0, 0, 32'h00, 0, 1, 32'h24, 1);
    vecs[19] = mk(0, 0, 32'h00, 1, 0, 32'h00, 1);

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].flush, vecs[i].in_valid, vecs[i].in_pc, vecs[i].out_ready);
      chk_out($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_ready);
    end

    // Reset while full: no effect until the clock edge, then empty.
    step(0, 1, 32'h50, 0);
    step(0, 1, 32'h54, 0);
    chk_out("full_pre_rst", 1'b1, 32'h50, 1'b0);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    chk_out("rst_no_edge", 1'b1, 32'h50, 1'b0);
    @(posedge clk);
    #1;
    chk_out("rst_edge", 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    // Skid contents must not resurface after reset.
    step(0, 1, 32'h58, 0);
    chk_out("post_rst_push", 1'b1, 32'h58, 1'b1);
    step(0, 0, 32'h0, 1);
    chk_out("post_rst_drain", 1'b0, 32'h0, 1'b1);

`ifdef IF_ID_STATS_EN
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("cnt_rst_stall", stall_cnt, 32'd0);
    chk("cnt_rst_flush", flush_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(0, 1, 32'h60, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 1);
    step(1, 0, 32'h0, 1);
    step(1, 0, 32'h0, 1);
    step(0, 0, 32'h0, 1);
    chk("stall_cnt_3", stall_cnt, 32'd3);
    chk("flush_cnt_2", flush_cnt, 32'd2);
    step(0, 1, 32'h64, 0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    @(posedge clk);
    #1;
    chk("stall_cnt_wrap", stall_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_if_id_skid_reg
